// File: rtl/uart_line_partner.sv
`default_nettype none
// ============================================================================
//  Module   : uart_line_partner (with helper uart_lp_fifo)
//  Purpose  : Far-end serial partner for the emulated UART chips. Converts
//             the async line to/from byte streams with valid/ready handshakes.
//             Each direction is buffered by a FIFO. The block also drives the
//             chip's modem-status inputs and honours its rts_n flow control.
//  Ports    : clk, reset (sync, active-high)
//             baud_div_i     16x-oversample tick period minus 1
//             wordlen_i      0=8,1=7,2=6,3=5 data bits
//             parity_en_i    parity bit present
//             parity_ctrl_i  0=odd,1=even,2=mark,3=space
//             flow_en_i      gate TX on rts_n_i
//             carrier_i      remote carrier present
//             in_*           TX byte stream (valid/ready)
//             out_*          RX byte stream (FWFT valid/ready)
//             ser_rx_i       line from the chip's tx (async)
//             ser_tx_o       line to the chip's rx
//             rts_n_i        chip request-to-send
//             cts_n_o        clear-to-send toward the chip
//             dsr_n_o        data-set-ready toward the chip
//             dcd_n_o        carrier detect toward the chip
//             err_*_o        sticky framing/parity/overrun flags
//             clr_err_i      clears all error flags
//  Revision : 1.0 - initial release
// ============================================================================

// Byte FIFO with first-word fall-through read. The caller qualifies the
// enables: a write while full happens only together with a read.
module uart_lp_fifo #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en_i,
   input  logic [7:0]    wr_data_i,
   input  logic          rd_en_i,
   output logic [7:0]    rd_data_o,
   output logic [AW:0]   count_o
);
   localparam int DEPTH = 1 << AW;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   count_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en_i) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (rd_en_i) begin
            rptr_q <= rptr_q + AW'(1);
         end
         case ({wr_en_i, rd_en_i})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rd_data_o = mem_q[rptr_q];
   assign count_o   = count_q;
endmodule

module uart_line_partner #(
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] baud_div_i,
   input  logic [1:0]  wordlen_i,
   input  logic        parity_en_i,
   input  logic [1:0]  parity_ctrl_i,
   input  logic        flow_en_i,
   input  logic        carrier_i,
   input  logic [7:0]  in_data_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output logic [7:0]  out_data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   input  logic        ser_rx_i,
   output logic        ser_tx_o,
   input  logic        rts_n_i,
   output logic        cts_n_o,
   output logic        dsr_n_o,
   output logic        dcd_n_o,
   output logic        err_fe_o,
   output logic        err_pe_o,
   output logic        err_ovr_o,
   input  logic        clr_err_i
);
   localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

   // Parity bit for a (pre-masked) data word.
   function automatic logic f_parity(input logic [7:0] d, input logic [1:0] ctrl);
      case (ctrl)
         2'd0:    f_parity = ~(^d);
         2'd1:    f_parity = ^d;
         2'd2:    f_parity = 1'b1;
         default: f_parity = 1'b0;
      endcase
   endfunction

   // ---------------------------------------------------------------- tick
   logic [15:0] baud_cnt_q;
   logic        tick;

   // >= rather than == so a baud_div reduced below the running count
   // cannot strand the counter for a full 16-bit wrap.
   assign tick = (baud_cnt_q >= baud_div_i);

   always_ff @(posedge clk) begin
      if (reset || tick) begin
         baud_cnt_q <= '0;
      end else begin
         baud_cnt_q <= baud_cnt_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------- TX
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   tx_state_t        tx_state_q;
   logic [7:0]       tx_shift_q;
   logic [2:0]       tx_bit_q;
   logic [2:0]       tx_last_q;
   logic             tx_par_en_q;
   logic             tx_par_q;
   logic [3:0]       tx_tcnt_q;
   logic             ser_tx_q;
   logic [FIFO_AW:0] tx_count;
   logic [7:0]       tx_head;
   logic [7:0]       tx_word;
   logic             tx_start;

   assign tx_word  = tx_head & (8'hFF >> wordlen_i);
   // rts_n is only consulted here, so a frame already on the wire finishes.
   assign tx_start = (tx_state_q == TX_IDLE) && tick && (tx_count != '0) &&
                     (!flow_en_i || !rts_n_i);

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q  <= TX_IDLE;
         tx_shift_q  <= '0;
         tx_bit_q    <= '0;
         tx_last_q   <= '0;
         tx_par_en_q <= 1'b0;
         tx_par_q    <= 1'b0;
         tx_tcnt_q   <= '0;
         ser_tx_q    <= 1'b1;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               ser_tx_q <= 1'b1;
               if (tx_start) begin
                  tx_state_q  <= TX_START;
                  ser_tx_q    <= 1'b0;
                  tx_tcnt_q   <= '0;
                  tx_shift_q  <= tx_word;
                  tx_bit_q    <= '0;
                  tx_last_q   <= 3'd7 - {1'b0, wordlen_i};
                  tx_par_en_q <= parity_en_i;
                  tx_par_q    <= f_parity(tx_word, parity_ctrl_i);
               end
            end
            default: begin
               if (tick) begin
                  tx_tcnt_q <= tx_tcnt_q + 4'd1;
                  if (tx_tcnt_q == 4'd15) begin
                     case (tx_state_q)
                        TX_START: begin
                           tx_state_q <= TX_DATA;
                           ser_tx_q   <= tx_shift_q[0];
                        end
                        TX_DATA: begin
                           if (tx_bit_q == tx_last_q) begin
                              if (tx_par_en_q) begin
                                 tx_state_q <= TX_PARITY;
                                 ser_tx_q   <= tx_par_q;
                              end else begin
                                 tx_state_q <= TX_STOP;
                                 ser_tx_q   <= 1'b1;
                              end
                           end else begin
                              tx_bit_q   <= tx_bit_q + 3'd1;
                              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                              ser_tx_q   <= tx_shift_q[1];
                           end
                        end
                        TX_PARITY: begin
                           tx_state_q <= TX_STOP;
                           ser_tx_q   <= 1'b1;
                        end
                        default: begin
                           tx_state_q <= TX_IDLE;
                           ser_tx_q   <= 1'b1;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

   uart_lp_fifo #(.AW(FIFO_AW)) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (in_valid_i && in_ready_o),
      .wr_data_i (in_data_i),
      .rd_en_i   (tx_start),
      .rd_data_o (tx_head),
      .count_o   (tx_count)
   );

   assign in_ready_o = (tx_count != DEPTH);
   assign ser_tx_o   = ser_tx_q;

   // ---------------------------------------------------------------- RX
   typedef enum logic [2:0] {
      RX_HUNT   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4,
      RX_BREAK  = 3'd5
   } rx_state_t;

   logic             rx_s1_q;
   logic             rx_s2_q;
   logic             rx_s3_q;
   rx_state_t        rx_state_q;
   logic [3:0]       rx_tcnt_q;
   logic [7:0]       rx_shift_q;
   logic [2:0]       rx_bit_q;
   logic [2:0]       rx_last_q;
   logic [1:0]       rx_wl_q;
   logic             rx_par_en_q;
   logic [1:0]       rx_ctrl_q;
   logic             rx_par_q;
   logic             rx_push_q;
   logic [7:0]       rx_byte_q;
   logic             rx_sample;
   logic [7:0]       rx_data;
   logic             rx_stop;
   logic [FIFO_AW:0] rx_count;
   logic             rx_full;
   logic             rx_pop;

   // Two-flop synchronizer; rx_s3_q is only the edge-detect history.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
      end else begin
         rx_s1_q <= ser_rx_i;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   assign rx_sample = tick && (rx_tcnt_q == 4'd15);
   // Bits arrive into the MSB, so a short word sits high; shift it down.
   assign rx_data   = rx_shift_q >> rx_wl_q;
   assign rx_stop   = (rx_state_q == RX_STOP) && rx_sample;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q  <= RX_HUNT;
         rx_tcnt_q   <= '0;
         rx_shift_q  <= '0;
         rx_bit_q    <= '0;
         rx_last_q   <= '0;
         rx_wl_q     <= '0;
         rx_par_en_q <= 1'b0;
         rx_ctrl_q   <= '0;
         rx_par_q    <= 1'b0;
         rx_push_q   <= 1'b0;
         rx_byte_q   <= '0;
      end else begin
         rx_push_q <= 1'b0;
         case (rx_state_q)
            RX_HUNT: begin
               if (rx_s3_q && !rx_s2_q) begin
                  rx_state_q  <= RX_START;
                  rx_tcnt_q   <= '0;
                  rx_shift_q  <= '0;
                  rx_bit_q    <= '0;
                  rx_last_q   <= 3'd7 - {1'b0, wordlen_i};
                  rx_wl_q     <= wordlen_i;
                  rx_par_en_q <= parity_en_i;
                  rx_ctrl_q   <= parity_ctrl_i;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (rx_tcnt_q == 4'd7) begin
                     rx_tcnt_q  <= '0;
                     rx_state_q <= rx_s2_q ? RX_HUNT : RX_DATA;
                  end else begin
                     rx_tcnt_q <= rx_tcnt_q + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  rx_tcnt_q <= rx_tcnt_q + 4'd1;
               end
               if (rx_sample) begin
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  if (rx_bit_q == rx_last_q) begin
                     rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
                  end else begin
                     rx_bit_q <= rx_bit_q + 3'd1;
                  end
               end
            end
            RX_PARITY: begin
               if (tick) begin
                  rx_tcnt_q <= rx_tcnt_q + 4'd1;
               end
               if (rx_sample) begin
                  rx_par_q   <= rx_s2_q;
                  rx_state_q <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (tick) begin
                  rx_tcnt_q <= rx_tcnt_q + 4'd1;
               end
               if (rx_sample) begin
                  rx_push_q  <= 1'b1;
                  rx_byte_q  <= rx_data;
                  rx_state_q <= rx_s2_q ? RX_HUNT : RX_BREAK;
               end
            end
            RX_BREAK: begin
               // A low stop bit may be a break; do not hunt until idle.
               if (rx_s2_q) begin
                  rx_state_q <= RX_HUNT;
               end
            end
            default: rx_state_q <= RX_HUNT;
         endcase
      end
   end

   assign rx_full = (rx_count == DEPTH);
   assign rx_pop  = out_valid_o && out_ready_i;

   uart_lp_fifo #(.AW(FIFO_AW)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (rx_push_q && (!rx_full || rx_pop)),
      .wr_data_i (rx_byte_q),
      .rd_en_i   (rx_pop),
      .rd_data_o (out_data_o),
      .count_o   (rx_count)
   );

   assign out_valid_o = (rx_count != '0);
   // Deassert clear-to-send once fewer than two entries are free.
   assign cts_n_o     = (rx_count > (DEPTH - (FIFO_AW+1)'(2)));
   assign dsr_n_o     = 1'b0;

   // ---------------------------------------------------------------- modem / errors
   logic dcd_n_q;
   logic err_fe_q;
   logic err_pe_q;
   logic err_ovr_q;
   logic fe_set;
   logic pe_set;
   logic ovr_set;

   assign fe_set  = rx_stop && !rx_s2_q;
   assign pe_set  = rx_stop && rx_par_en_q && !rx_ctrl_q[1] &&
                    (rx_par_q != f_parity(rx_data, rx_ctrl_q));
   assign ovr_set = rx_push_q && rx_full && !rx_pop;

   always_ff @(posedge clk) begin
      dcd_n_q <= ~carrier_i;
   end

   always_ff @(posedge clk) begin
      if (reset || clr_err_i) begin
         err_fe_q  <= 1'b0;
         err_pe_q  <= 1'b0;
         err_ovr_q <= 1'b0;
      end else begin
         err_fe_q  <= err_fe_q  | fe_set;
         err_pe_q  <= err_pe_q  | pe_set;
         err_ovr_q <= err_ovr_q | ovr_set;
      end
   end

   assign dcd_n_o   = dcd_n_q;
   assign err_fe_o  = err_fe_q;
   assign err_pe_o  = err_pe_q;
   assign err_ovr_o = err_ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_line_partner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_line_partner
//  Purpose  : Directed self-checking bench for uart_line_partner. Expected
//             RX bytes and TX line levels are queued when stimulus is driven
//             and popped when the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_line_partner;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] baud_div;
   logic [1:0]  wordlen;
   logic        parity_en;
   logic [1:0]  parity_ctrl;
   logic        flow_en;
   logic        carrier;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        ser_rx;
   logic        ser_tx;
   logic        rts_n;
   logic        cts_n;
   logic        dsr_n;
   logic        dcd_n;
   logic        err_fe;
   logic        err_pe;
   logic        err_ovr;
   logic        clr_err;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];   // expected received bytes
   logic       bit_q[$];   // expected TX line level per bit period

   always #5 clk = ~clk;

   uart_line_partner #(.FIFO_AW(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .baud_div_i    (baud_div),
      .wordlen_i     (wordlen),
      .parity_en_i   (parity_en),
      .parity_ctrl_i (parity_ctrl),
      .flow_en_i     (flow_en),
      .carrier_i     (carrier),
      .in_data_i     (in_data),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .out_data_o    (out_data),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .ser_rx_i      (ser_rx),
      .ser_tx_o      (ser_tx),
      .rts_n_i       (rts_n),
      .cts_n_o       (cts_n),
      .dsr_n_o       (dsr_n),
      .dcd_n_o       (dcd_n),
      .err_fe_o      (err_fe),
      .err_pe_o      (err_pe),
      .err_ovr_o     (err_ovr),
      .clr_err_i     (clr_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference parity over the low nb bits of d.
   function automatic logic model_par(input logic [7:0] d, input int nb, input logic [1:0] ctrl);
      logic [7:0] m;
      m = d & (8'hFF >> (8 - nb));
      case (ctrl)
         2'd0:    return ~(^m);
         2'd1:    return ^m;
         2'd2:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic expect_tx(input logic [7:0] d, input int nb, input logic pen, input logic [1:0] ctrl);
      bit_q.push_back(1'b0);
      for (int i = 0; i < nb; i++) bit_q.push_back(d[i]);
      if (pen) bit_q.push_back(model_par(d, nb, ctrl));
      bit_q.push_back(1'b1);
   endtask

   task automatic push(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_tx_low(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (ser_tx == 1'b0) break;
         step();
      end
      chk(tag, 16'(ser_tx), 16'd0);
   endtask

   // Each bit must hold for exactly 16 clks (baud_div = 0): check first and last clk.
   task automatic check_tx_bits(input string tag);
      int   n;
      logic cur;
      n   = bit_q.size();
      cur = 1'b1;
      for (int c = 0; c < n * 16; c++) begin
         if (c % 16 == 0) cur = bit_q.pop_front();
         if ((c % 16 == 0) || (c % 16 == 15)) chk(tag, 16'(ser_tx), 16'(cur));
         step();
      end
   endtask

   task automatic send_rx(input logic [7:0] d, input int nb, input logic pen,
                          input logic pb, input logic stopb);
      ser_rx = 1'b0;
      steps(16);
      for (int i = 0; i < nb; i++) begin
         ser_rx = d[i];
         steps(16);
      end
      if (pen) begin
         ser_rx = pb;
         steps(16);
      end
      ser_rx = stopb;
      steps(16);
      ser_rx = 1'b1;
      steps(2);
   endtask

   task automatic recv(input string tag);
      for (int i = 0; i < 64; i++) begin
         if (out_valid) break;
         step();
      end
      chk({tag, "_valid"}, 16'(out_valid), 16'd1);
      if (exp_q.size() > 0) chk({tag, "_data"}, 16'(out_data), 16'(exp_q.pop_front()));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      reset       = 1'b1;
      baud_div    = 16'd0;
      wordlen     = 2'd0;
      parity_en   = 1'b0;
      parity_ctrl = 2'd0;
      flow_en     = 1'b0;
      carrier     = 1'b1;
      in_data     = 8'h00;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      ser_rx      = 1'b1;
      rts_n       = 1'b0;
      clr_err     = 1'b0;
      steps(3);

      // Reset values
      chk("rst_ser_tx",    16'(ser_tx),    16'd1);
      chk("rst_in_ready",  16'(in_ready),  16'd1);
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_cts_n",     16'(cts_n),     16'd0);
      chk("rst_dsr_n",     16'(dsr_n),     16'd0);
      chk("rst_dcd_n",     16'(dcd_n),     16'd0);
      chk("rst_err_fe",    16'(err_fe),    16'd0);
      chk("rst_err_pe",    16'(err_pe),    16'd0);
      chk("rst_err_ovr",   16'(err_ovr),   16'd0);
      reset = 1'b0;
      step();

      // Carrier detect follows ~carrier one cycle later
      carrier = 1'b0;
      step();
      chk("dcd_off", 16'(dcd_n), 16'd1);
      carrier = 1'b1;
      step();
      chk("dcd_on", 16'(dcd_n), 16'd0);

      // 8N1 TX of 0x55
      expect_tx(8'h55, 8, 1'b0, 2'd0);
      push(8'h55);
      wait_tx_low("tx8n1_start", 4);
      chk("tx8n1_in_ready", 16'(in_ready), 16'd1);
      check_tx_bits("tx8n1_bit");
      chk("tx8n1_idle", 16'(ser_tx), 16'd1);

      // 8E1 RX, good then bad parity
      parity_en   = 1'b1;
      parity_ctrl = 2'd1;
      exp_q.push_back(8'hA5);
      send_rx(8'hA5, 8, 1'b1, 1'b0, 1'b1);
      recv("rx8e1");
      chk("rx8e1_pe", 16'(err_pe), 16'd0);
      chk("rx8e1_fe", 16'(err_fe), 16'd0);
      exp_q.push_back(8'hA5);
      send_rx(8'hA5, 8, 1'b1, 1'b1, 1'b1);
      recv("rx8e1_bad");
      chk("rx8e1_bad_pe", 16'(err_pe), 16'd1);
      pulse_clr();
      chk("rx8e1_clr_pe", 16'(err_pe), 16'd0);

      // Framing error and break
      parity_en = 1'b0;
      exp_q.push_back(8'h81);
      send_rx(8'h81, 8, 1'b0, 1'b0, 1'b0);
      chk("fe_set", 16'(err_fe), 16'd1);
      recv("fe_byte");
      pulse_clr();
      chk("fe_clr", 16'(err_fe), 16'd0);

      exp_q.push_back(8'h00);
      ser_rx = 1'b0;
      steps(30 * 16);
      ser_rx = 1'b1;
      steps(32);
      recv("break_byte");
      chk("break_fe", 16'(err_fe), 16'd1);
      step();
      chk("break_once", 16'(out_valid), 16'd0);
      pulse_clr();
      exp_q.push_back(8'h3C);
      send_rx(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      recv("after_break");
      chk("after_break_fe", 16'(err_fe), 16'd0);

      // Overflow and CTS
      for (int i = 0; i < 15; i++) begin
         exp_q.push_back(8'(i + 1));
         send_rx(8'(i + 1), 8, 1'b0, 1'b0, 1'b1);
         if (i == 13) chk("cts_14", 16'(cts_n), 16'd0);
      end
      chk("cts_15", 16'(cts_n), 16'd1);
      exp_q.push_back(8'h10);
      send_rx(8'h10, 8, 1'b0, 1'b0, 1'b1);
      chk("ovr_16", 16'(err_ovr), 16'd0);
      send_rx(8'h11, 8, 1'b0, 1'b0, 1'b1);
      chk("ovr_17", 16'(err_ovr), 16'd1);
      chk("ovr_head", 16'(out_data), 16'(exp_q[0]));
      while (exp_q.size() > 0) recv("ovr_drain");
      chk("ovr_empty", 16'(out_valid), 16'd0);
      chk("ovr_cts", 16'(cts_n), 16'd0);
      pulse_clr();

      // Flow control
      flow_en = 1'b1;
      rts_n   = 1'b1;
      expect_tx(8'h12, 8, 1'b0, 2'd0);
      push(8'h12);
      lows = 0;
      repeat (100) begin
         if (!ser_tx) lows++;
         step();
      end
      chk("flow_hold", 16'(lows), 16'd0);
      rts_n = 1'b0;
      wait_tx_low("flow_start", 3);
      rts_n = 1'b1;
      check_tx_bits("flow_bit");
      rts_n   = 1'b0;
      flow_en = 1'b0;

      // 5O1 TX and RX
      wordlen     = 2'd3;
      parity_en   = 1'b1;
      parity_ctrl = 2'd0;
      expect_tx(8'hFF, 5, 1'b1, 2'd0);
      push(8'hFF);
      wait_tx_low("tx5o1_start", 4);
      check_tx_bits("tx5o1_bit");
      exp_q.push_back(8'h15);
      send_rx(8'h15, 5, 1'b1, model_par(8'h15, 5, 2'd0), 1'b1);
      recv("rx5o1");
      chk("rx5o1_pe", 16'(err_pe), 16'd0);
      wordlen   = 2'd0;
      parity_en = 1'b0;

      // Glitch reject
      ser_rx = 1'b0;
      steps(4);
      ser_rx = 1'b1;
      steps(200);
      chk("glitch_none", 16'(out_valid), 16'd0);
      exp_q.push_back(8'h5A);
      send_rx(8'h5A, 8, 1'b0, 1'b0, 1'b1);
      recv("post_glitch");

      // Reset mid-TX with more bytes queued
      push(8'h00);
      push(8'h01);
      push(8'h02);
      wait_tx_low("rst_tx_start", 4);
      steps(40);
      reset = 1'b1;
      step();
      chk("rst_mid_ser_tx", 16'(ser_tx), 16'd1);
      chk("rst_mid_in_ready", 16'(in_ready), 16'd1);
      reset = 1'b0;
      lows  = 0;
      repeat (50) begin
         step();
         if (!ser_tx) lows++;
      end
      chk("rst_mid_quiet", 16'(lows), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
